// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 scan controller slice.
package seg7_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Active-low anodes: all ones means every digit is dark.
  function automatic logic [MAX_DIGITS-1:0] all_off();
    return '1;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot down-counter: loaded with (cycles-1), slot_end_o is high on the final cycle of the slot.
module seg7_slot_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             slot_end_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign slot_end_o = (cnt_q == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned display updates.
// Optional leading-zero suppression is compiled in with SEG7_LZ_SUPPRESS_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           load_valid,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
  output logic                           load_ready,
  input  logic [NUM_DIGITS-1:0]          blank_mask,
  output logic [NIBBLE_W-1:0]            nibble,
  output logic [NUM_DIGITS-1:0]          digit_en_n,
  output logic                           frame_done
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]      DIGIT_LOAD = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [MAX_DIGITS-1:0] ALL_OFF_W  = all_off();
  localparam logic [NUM_DIGITS-1:0] ALL_OFF    = ALL_OFF_W[NUM_DIGITS-1:0];

  state_e                                   state_q, state_d;
  logic [IDX_W-1:0]                         idx_q, idx_d, idx_next;
  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0]      staging_q, staging_d;
  logic                                     pending_q, pending_d;
  logic                                     tmr_load, slot_end, frame_end;
  logic [CNT_W-1:0]                         tmr_val;
  logic [NUM_DIGITS-1:0]                    lz_dark, dark;

  seg7_slot_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .slot_end_o (slot_end)
  );

  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    frame_end = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_SHOW;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = DIGIT_LOAD;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          tmr_load = 1'b1;
        end else if (slot_end) begin
          tmr_load = 1'b1;
          if (BLANK_CYCLES > 0) begin
            state_d = ST_BLANK;
            tmr_val = BLANK_LOAD;
          end else begin
            // Without a blanking gap the slot ends here, so the frame does too.
            state_d   = ST_SHOW;
            idx_d     = idx_next;
            tmr_val   = DIGIT_LOAD;
            frame_end = (idx_q == LAST_IDX);
          end
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          tmr_load = 1'b1;
        end else if (slot_end) begin
          state_d   = ST_SHOW;
          idx_d     = idx_next;
          tmr_load  = 1'b1;
          tmr_val   = DIGIT_LOAD;
          frame_end = (idx_q == LAST_IDX);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Copy uses pending_q, so a word accepted on the boundary cycle waits a full frame.
  always_comb begin
    shadow_d  = shadow_q;
    staging_d = staging_q;
    pending_d = pending_q;
    if (pending_q && (frame_end || (state_q == ST_IDLE))) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end
    if (load_valid && !pending_q) begin
      staging_d = load_data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      staging_q <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      staging_q <= staging_d;
      pending_q <= pending_d;
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_dark    = '0;
    for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (shadow_q[i] == '0);
      lz_dark[i] = zero_above;
    end
  end
`else
  always_comb begin
    lz_dark = '0;
  end
`endif

  assign dark = blank_mask | lz_dark;

  always_comb begin
    digit_en_n = ALL_OFF;
    if ((state_q == ST_SHOW) && !dark[idx_q]) begin
      digit_en_n[idx_q] = 1'b0;
    end
  end

  assign nibble     = (state_q == ST_IDLE) ? '0 : shadow_q[idx_q];
  assign load_ready = ~pending_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (4 digits, 4 lit + 1 blank cycle per slot).
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  blank_mask;
  logic [3:0]  nibble;
  logic [3:0]  digit_en_n;
  logic        frame_done;

  typedef struct {
    logic [3:0] en;
    logic [3:0] nib;
    logic       fd;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .blank_mask (blank_mask),
    .nibble     (nibble),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Monitor: every cycle the DUT presents a full output set; compare on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      compared++;
      if (digit_en_n !== e.en) begin
        mismatched++;
        $display("FAIL %s digit_en_n: got %b expected %b", e.tag, digit_en_n, e.en);
      end
      compared++;
      if (nibble !== e.nib) begin
        mismatched++;
        $display("FAIL %s nibble: got %h expected %h", e.tag, nibble, e.nib);
      end
      compared++;
      if (frame_done !== e.fd) begin
        mismatched++;
        $display("FAIL %s frame_done: got %b expected %b", e.tag, frame_done, e.fd);
      end
      compared++;
      if (load_ready !== e.rdy) begin
        mismatched++;
        $display("FAIL %s load_ready: got %b expected %b", e.tag, load_ready, e.rdy);
      end
    end
  end

  task automatic push_and_step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input logic rdy, input string tag);
    exp_t e;
    e.en  = 4'hF;
    e.nib = 4'h0;
    e.fd  = 1'b0;
    e.rdy = rdy;
    e.tag = tag;
    push_and_step(e);
  endtask

  // Position p in a 20-cycle frame: slot p/5, lit for the first 4 cycles of each slot.
  task automatic cyc(input int p, input logic [15:0] sh, input logic [3:0] mask,
                     input logic rdy, input string tag);
    exp_t e;
    int   slot;
    logic dark;
    blank_mask = mask;
    slot = p / 5;
    dark = mask[slot];
`ifdef SEG7_LZ_SUPPRESS_EN
    if (slot > 0 && (sh >> (4 * slot)) == 16'h0000) dark = 1'b1;
`endif
    e.en = 4'hF;
    if ((p % 5) < 4 && !dark) e.en[slot] = 1'b0;
    e.nib = sh[slot*4 +: 4];
    e.fd  = (p == 19);
    e.rdy = rdy;
    e.tag = $sformatf("%s p%0d", tag, p);
    push_and_step(e);
  endtask

  task automatic frame(input logic [15:0] sh, input logic [3:0] mask, input int rdy_until,
                       input int load_p, input logic [15:0] word, input int last_p,
                       input string tag);
    for (int p = 0; p <= last_p; p++) begin
      if (p == load_p) begin
        load_valid = 1'b1;
        load_data  = word;
      end else begin
        load_valid = 1'b0;
      end
      cyc(p, sh, mask, (p <= rdy_until), tag);
    end
    load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    blank_mask = '0;
    @(posedge clk);
    #1;
    idle_cyc(1'b1, "reset");
    idle_cyc(1'b1, "reset");
    rst = 1'b0;
    idle_cyc(1'b1, "idle_disabled");
    enable = 1'b1;
    idle_cyc(1'b1, "idle_to_show");

    frame(16'h0000, 4'b0000, 19, -1, 16'h0000, 19, "f_zero");
    frame(16'h0000, 4'b0000,  3,  3, 16'h1A3F, 19, "f_load");
    frame(16'h1A3F, 4'b0000, 19, 19, 16'h2B4C, 19, "f_show1");
    frame(16'h1A3F, 4'b0000, -1, -1, 16'h0000, 19, "f_held");
    frame(16'h2B4C, 4'b0100, 19, -1, 16'h0000, 19, "f_mask");

    frame(16'h2B4C, 4'b0000, 19, -1, 16'h0000, 11, "f_drop");
    enable = 1'b0;
    cyc(12, 16'h2B4C, 4'b0000, 1'b1, "f_drop");
    idle_cyc(1'b1, "en_low1");
    idle_cyc(1'b1, "en_low2");
    enable = 1'b1;
    idle_cyc(1'b1, "en_high");
    frame(16'h2B4C, 4'b0000, 19, -1, 16'h0000, 19, "f_restart");

    frame(16'h2B4C, 4'b0000, 19, -1, 16'h0000, 7, "f_prerst");
    #1 rst = 1'b1;
    idle_cyc(1'b1, "rst_async");
    idle_cyc(1'b1, "rst_held");
    rst = 1'b0;
    idle_cyc(1'b1, "rst_release");
    frame(16'h0000, 4'b0000,  0,  0, 16'h0050, 19, "f_lz_load");
    frame(16'h0050, 4'b0000, 19, -1, 16'h0000, 19, "f_lz");

    @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
